// File: rtl/snake_mover_if.sv
// Bundle of the snake movement engine's control, status and segment read-port signals.
interface snake_mover_if #(
    parameter int unsigned XW = 3,
    parameter int unsigned YW = 3,
    parameter int unsigned LW = 6
) ();
    logic          tick;
    logic          start;
    logic          btn_up;
    logic          btn_down;
    logic          btn_left;
    logic          btn_right;
    logic          grow;
    logic [LW-1:0] rd_idx;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_valid;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [LW-1:0] length;
    logic          step_done;
    logic          game_over;
    logic          tick_miss;

    modport master (
        output tick, start, btn_up, btn_down, btn_left, btn_right, grow, rd_idx,
        input  rd_x, rd_y, rd_valid, head_x, head_y, length, step_done, game_over, tick_miss
    );

    modport slave (
        input  tick, start, btn_up, btn_down, btn_left, btn_right, grow, rd_idx,
        output rd_x, rd_y, rd_valid, head_x, head_y, length, step_done, game_over, tick_miss
    );
endinterface

// File: rtl/snake_mover.sv
// Snake movement engine: circular body buffer, tick-driven step with serial self-collision scan.
// Define SNAKE_WRAP_EN to wrap at grid edges instead of ending the game.
module snake_mover #(
    parameter int unsigned GRID_W   = 8,
    parameter int unsigned GRID_H   = 8,
    parameter int unsigned XW       = 3,
    parameter int unsigned YW       = 3,
    parameter int unsigned MAX_LEN  = 32,
    parameter int unsigned LW       = 6,
    parameter int unsigned INIT_LEN = 3
) (
    input logic          clk,
    input logic          rst_n,
    snake_mover_if.slave bus
);
    localparam int unsigned PW = $clog2(MAX_LEN);

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_STEP   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;
    localparam logic [2:0] S_OVER   = 3'd6;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    logic [2:0]    state_q, state_d;
    logic [1:0]    dir_q, next_dir_q;
    logic [PW-1:0] head_ptr_q;
    logic [LW-1:0] len_q, n_q, k_q;
    logic [XW-1:0] head_x_q, cand_x_q, step_x;
    logic [YW-1:0] head_y_q, cand_y_q, step_y;
    logic          grow_pend_q, step_done_q, tick_miss_q;
    logic          off_grid, req_vld, accept, hit, busy;
    logic [1:0]    req_dir;
    logic [PW-1:0] chk_addr, rd_addr;

    logic [XW-1:0] buf_x [MAX_LEN];
    logic [YW-1:0] buf_y [MAX_LEN];

    always_comb begin
        req_vld = 1'b1;
        req_dir = DIR_RIGHT;
        if (bus.btn_up)         req_dir = DIR_UP;
        else if (bus.btn_down)  req_dir = DIR_DOWN;
        else if (bus.btn_left)  req_dir = DIR_LEFT;
        else if (bus.btn_right) req_dir = DIR_RIGHT;
        else                    req_vld = 1'b0;
    end

    // Opposite directions differ only in bit 1.
    assign accept = req_vld && (req_dir != (dir_q ^ 2'd2));

    always_comb begin
        step_x   = head_x_q;
        step_y   = head_y_q;
        off_grid = 1'b0;
        unique case (next_dir_q)
            DIR_UP: begin
                if (head_y_q == '0) begin
                    off_grid = 1'b1;
                    step_y   = YW'(GRID_H - 1);
                end else step_y = head_y_q - 1'b1;
            end
            DIR_RIGHT: begin
                if (head_x_q == XW'(GRID_W - 1)) begin
                    off_grid = 1'b1;
                    step_x   = '0;
                end else step_x = head_x_q + 1'b1;
            end
            DIR_DOWN: begin
                if (head_y_q == YW'(GRID_H - 1)) begin
                    off_grid = 1'b1;
                    step_y   = '0;
                end else step_y = head_y_q + 1'b1;
            end
            DIR_LEFT: begin
                if (head_x_q == '0) begin
                    off_grid = 1'b1;
                    step_x   = XW'(GRID_W - 1);
                end else step_x = head_x_q - 1'b1;
            end
        endcase
    end

    assign chk_addr = head_ptr_q - PW'(k_q);
    assign hit      = (buf_x[chk_addr] == cand_x_q) && (buf_y[chk_addr] == cand_y_q);
    assign busy     = (state_q == S_STEP) || (state_q == S_CHECK) || (state_q == S_COMMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_INIT;
            S_INIT:   state_d = S_RUN;
            S_RUN:    if (bus.tick) state_d = S_STEP;
            S_STEP:   state_d = (off_grid && !WRAP) ? S_OVER : S_CHECK;
            S_CHECK: begin
                if (hit)                       state_d = S_OVER;
                else if (k_q == n_q - 1'b1)    state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_RUN;
            S_OVER:   if (bus.start) state_d = S_INIT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dir_q       <= DIR_RIGHT;
            next_dir_q  <= DIR_RIGHT;
            head_ptr_q  <= '0;
            len_q       <= '0;
            n_q         <= '0;
            k_q         <= '0;
            head_x_q    <= '0;
            head_y_q    <= '0;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            grow_pend_q <= 1'b0;
            step_done_q <= 1'b0;
            tick_miss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_done_q <= 1'b0;
            tick_miss_q <= bus.tick && busy;
            if (accept) next_dir_q <= req_dir;
            if (bus.grow && (busy || state_q == S_RUN)) grow_pend_q <= 1'b1;
            case (state_q)
                S_INIT: begin
                    len_q       <= LW'(INIT_LEN);
                    head_x_q    <= XW'(GRID_W / 2);
                    head_y_q    <= YW'(GRID_H / 2);
                    head_ptr_q  <= '0;
                    dir_q       <= DIR_RIGHT;
                    next_dir_q  <= DIR_RIGHT;
                    grow_pend_q <= 1'b0;
                end
                S_STEP: begin
                    dir_q    <= next_dir_q;
                    cand_x_q <= step_x;
                    cand_y_q <= step_y;
                    n_q      <= grow_pend_q ? len_q : len_q - 1'b1;
                    k_q      <= '0;
                end
                S_CHECK: k_q <= k_q + 1'b1;
                S_COMMIT: begin
                    head_ptr_q  <= head_ptr_q + 1'b1;
                    head_x_q    <= cand_x_q;
                    head_y_q    <= cand_y_q;
                    if (grow_pend_q && (len_q < LW'(MAX_LEN))) len_q <= len_q + 1'b1;
                    grow_pend_q <= bus.grow;
                    step_done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Body storage needs no reset; length alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            for (int i = 0; i < INIT_LEN; i++) begin
                buf_x[PW'(MAX_LEN - i)] <= XW'(GRID_W / 2 - i);
                buf_y[PW'(MAX_LEN - i)] <= YW'(GRID_H / 2);
            end
        end else if (state_q == S_COMMIT) begin
            buf_x[head_ptr_q + 1'b1] <= cand_x_q;
            buf_y[head_ptr_q + 1'b1] <= cand_y_q;
        end
    end

    assign rd_addr       = head_ptr_q - PW'(bus.rd_idx);
    assign bus.rd_valid  = bus.rd_idx < len_q;
    assign bus.rd_x      = bus.rd_valid ? buf_x[rd_addr] : '0;
    assign bus.rd_y      = bus.rd_valid ? buf_y[rd_addr] : '0;
    assign bus.head_x    = head_x_q;
    assign bus.head_y    = head_y_q;
    assign bus.length    = len_q;
    assign bus.step_done = step_done_q;
    assign bus.game_over = (state_q == S_OVER);
    assign bus.tick_miss = tick_miss_q;
endmodule

// File: tb/tb_snake_mover.sv
// Scoreboard bench for snake_mover: directed moves queue expected outcomes, a monitor checks them.
module tb_snake_mover;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   miss_cnt = 0;
    int   done_cnt = 0;

    typedef struct {
        string name;
        bit    over;
        int    x;
        int    y;
        int    len;
    } exp_t;

    exp_t exp_q[$];

    snake_mover_if bus ();

    snake_mover dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input int d);
        bus.btn_up    = (d == 0);
        bus.btn_right = (d == 1);
        bus.btn_down  = (d == 2);
        bus.btn_left  = (d == 3);
        cyc();
        bus.btn_up = 0; bus.btn_right = 0; bus.btn_down = 0; bus.btn_left = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1;
        cyc();
        bus.start = 0;
        cyc();
    endtask

    task automatic wait_evt(input string name, input int already, input int lat);
        int n = already;
        while (!(bus.step_done || bus.game_over) && n < 80) begin
            cyc();
            n++;
        end
        chk({name, "_latency"}, n, lat);
        cyc();
    endtask

    task automatic step(input string name, input bit over, input int x, input int y,
                        input int len, input int lat);
        exp_q.push_back('{name, over, x, y, len});
        bus.tick = 1;
        cyc();
        bus.tick = 0;
        wait_evt(name, 1, lat);
    endtask

    task automatic check_rd(input string name, input int idx, input int vld, input int x,
                            input int y);
        bus.rd_idx = 6'(idx);
        #1;
        chk({name, "_valid"}, int'(bus.rd_valid), vld);
        chk({name, "_x"}, int'(bus.rd_x), x);
        chk({name, "_y"}, int'(bus.rd_y), y);
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_head_x"}, int'(bus.head_x), 0);
        chk({name, "_head_y"}, int'(bus.head_y), 0);
        chk({name, "_length"}, int'(bus.length), 0);
        chk({name, "_step_done"}, int'(bus.step_done), 0);
        chk({name, "_game_over"}, int'(bus.game_over), 0);
        chk({name, "_tick_miss"}, int'(bus.tick_miss), 0);
        chk({name, "_rd_valid"}, int'(bus.rd_valid), 0);
        chk({name, "_rd_x"}, int'(bus.rd_x), 0);
    endtask

    // Monitor: each step_done pulse or game_over rise consumes one queued expectation.
    initial begin
        bit   go_prev;
        exp_t e;
        go_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                go_prev = 0;
            end else begin
                if (bus.tick_miss) miss_cnt++;
                if (bus.step_done) done_cnt++;
                if (bus.step_done || (bus.game_over && !go_prev)) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_event: step_done=%0b game_over=%0b head=(%0d,%0d) len=%0d, none queued",
                                 bus.step_done, bus.game_over, bus.head_x, bus.head_y, bus.length);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.game_over !== e.over || bus.step_done === e.over ||
                            int'(bus.head_x) != e.x || int'(bus.head_y) != e.y ||
                            int'(bus.length) != e.len) begin
                            fails++;
                            $display("FAIL %s: got over=%0b head=(%0d,%0d) len=%0d, expected over=%0b head=(%0d,%0d) len=%0d",
                                     e.name, bus.game_over, bus.head_x, bus.head_y, bus.length,
                                     e.over, e.x, e.y, e.len);
                        end
                    end
                end
                go_prev = bus.game_over;
            end
        end
    end

    initial begin
        int dirs[30] = '{1, 1, 1, 0, 0, 0, 0, 3, 3, 3, 3, 3, 3, 3, 2,
                         1, 1, 1, 1, 1, 1, 2, 3, 3, 3, 3, 3, 3, 2, 1};
        int hx, hy, len, lat, miss0, done0;

        bus.tick = 0; bus.start = 0; bus.grow = 0; bus.rd_idx = '0;
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        rst_n = 0;
        repeat (3) cyc();
        check_cleared("reset");
        rst_n = 1;
        cyc();

        bus.tick = 1; cyc(); bus.tick = 0;
        repeat (8) cyc();
        chk("idle_tick_length", int'(bus.length), 0);
        chk("idle_tick_miss", miss_cnt, 0);

        // Basic step and read port
        pulse_start();
        chk("init_head_x", int'(bus.head_x), 4);
        chk("init_head_y", int'(bus.head_y), 4);
        chk("init_length", int'(bus.length), 3);
        check_rd("init_tail", 2, 1, 2, 4);
        step("t1_step", 0, 5, 4, 3, 5);
        check_rd("t1_tail", 2, 1, 3, 4);
        check_rd("t1_past_tail", 3, 0, 0, 0);

        // Reversal ignored; simultaneous requests resolved by priority
        press(3);
        step("t2_left_ignored", 0, 6, 4, 3, 5);
        bus.btn_up = 1; bus.btn_left = 1;
        cyc();
        bus.btn_up = 0; bus.btn_left = 0;
        step("t2_up", 0, 6, 3, 3, 5);

        bus.grow = 1; cyc(); bus.grow = 0;
        step("t3_grow", 0, 6, 2, 4, 6);
        check_rd("t3_old_tail", 3, 1, 5, 4);
        check_rd("t3_past_tail", 4, 0, 0, 0);

        // Coil into itself: hit on the fourth scanned segment
        bus.grow = 1; cyc(); bus.grow = 0;
        step("t4_up", 0, 6, 1, 5, 7);
        press(3);
        step("t4_left", 0, 5, 1, 5, 7);
        press(2);
        step("t4_down", 0, 5, 2, 5, 7);
        press(1);
        step("t4_self_hit", 1, 5, 2, 5, 6);
        chk("t4_over_held", int'(bus.game_over), 1);
        pulse_start();
        chk("t4_restart_over", int'(bus.game_over), 0);
        chk("t4_restart_x", int'(bus.head_x), 4);
        chk("t4_restart_y", int'(bus.head_y), 4);
        chk("t4_restart_len", int'(bus.length), 3);

        // Right edge
        step("t5_r1", 0, 5, 4, 3, 5);
        step("t5_r2", 0, 6, 4, 3, 5);
        step("t5_r3", 0, 7, 4, 3, 5);
`ifdef SNAKE_WRAP_EN
        step("t5_wrap", 0, 0, 4, 3, 5);
`else
        step("t5_edge", 1, 7, 4, 3, 2);
        chk("t5_edge_over", int'(bus.game_over), 1);
`endif

        // Grow to the buffer limit along a serpentine path
        rst_n = 0; cyc(); rst_n = 1; cyc();
        pulse_start();
        hx = 4; hy = 4; len = 3;
        for (int i = 0; i < 30; i++) begin
            lat = 3 + len;
            case (dirs[i])
                0: hy--;
                1: hx++;
                2: hy++;
                default: hx--;
            endcase
            if (len < 32) len++;
            bus.grow = 1;
            press(dirs[i]);
            bus.grow = 0;
            step($sformatf("t3_long_%0d", i), 0, hx, hy, len, lat);
        end
        chk("t3_max_len", int'(bus.length), 32);
        check_rd("t3_max_tail", 31, 1, 3, 4);
        check_rd("t3_max_past", 32, 0, 0, 0);

        // Extra tick during CHECK
        rst_n = 0; cyc(); rst_n = 1; cyc();
        pulse_start();
        miss0 = miss_cnt;
        done0 = done_cnt;
        exp_q.push_back('{"t6_miss_step", 0, 5, 4, 3});
        bus.tick = 1; cyc(); bus.tick = 0;
        cyc();
        bus.tick = 1; cyc(); bus.tick = 0;
        wait_evt("t6_miss_step", 3, 5);
        repeat (10) cyc();
        chk("t6_tick_miss_count", miss_cnt - miss0, 1);
        chk("t6_single_step", done_cnt - done0, 1);
        chk("t6_head_x", int'(bus.head_x), 5);

        // Reset while scanning
        done0 = done_cnt;
        bus.tick = 1; cyc(); bus.tick = 0;
        cyc();
        rst_n = 0;
        #2;
        check_cleared("t6_rst_check");
        cyc();
        rst_n = 1;
        repeat (10) cyc();
        chk("t6_rst_idle_len", int'(bus.length), 0);
        chk("t6_rst_no_step", done_cnt - done0, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
